// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: execute-side resolution of B-type branches.
// Two-stage valid/ready pipeline (A = operand capture + compare, B = output
// register). Redirects fetch on mispredict and kills the younger entry in A.
// Optional feature macro: BRU_STATS_EN (resolved-branch / redirect counters).

package bru_pkg;
   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_BEQ  = 4'd1,
      OP_BNE  = 4'd2,
      OP_BLT  = 4'd3,
      OP_BGE  = 4'd4,
      OP_BLTU = 4'd5,
      OP_BGEU = 4'd6
   } oper_t;
endpackage

module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int XLEN       = 64,
   parameter int ALIGN_BITS = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  oper_t           in_op,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_imm,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic            in_pred_taken,
   input  logic [XLEN-1:0] in_pred_target,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_taken,
   output logic [XLEN-1:0] out_next_pc,
   output logic            out_redirect,
   output logic            out_misalign,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
);

   localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);

   // Stage A registers
   logic            a_valid;
   oper_t           a_op;
   logic [XLEN-1:0] a_pc;
   logic [XLEN-1:0] a_imm;
   logic [XLEN-1:0] a_rs1;
   logic [XLEN-1:0] a_rs2;
   logic            a_pred_taken;
   logic [XLEN-1:0] a_pred_target;

   // Stage A resolved results
   logic            is_branch;
   logic            taken;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] fallthrough;
   logic [XLEN-1:0] next_pc;
   logic            misalign;
   logic            redirect;

   // Handshake terms
   logic b_fire;
   logic self_kill;
   logic a_advance;
   logic b_load;
   logic accept;

   assign b_fire    = out_valid && out_ready;
   // A redirecting result leaving B means whatever sits in A is wrong-path.
   assign self_kill = b_fire && out_redirect;
   assign a_advance = a_valid && (!out_valid || out_ready);
   assign b_load    = a_advance && !self_kill;
   assign in_ready  = !flush && !self_kill && (!a_valid || a_advance);
   assign accept    = in_valid && in_ready;

   // Resolve the stage-A branch: condition, target, next PC and prediction check
   always_comb begin
      logic eq;
      logic lt;
      logic ltu;
      eq          = (a_rs1 == a_rs2);
      lt          = ($signed(a_rs1) < $signed(a_rs2));
      ltu         = (a_rs1 < a_rs2);
      is_branch   = 1'b1;
      taken       = 1'b0;
      case (a_op)
         OP_BEQ:  taken = eq;
         OP_BNE:  taken = !eq;
         OP_BLT:  taken = lt;
         OP_BGE:  taken = !lt;
         OP_BLTU: taken = ltu;
         OP_BGEU: taken = !ltu;
         default: is_branch = 1'b0;
      endcase
      target      = a_pc + (a_imm << 1);
      fallthrough = a_pc + INSTR_BYTES;
      next_pc     = taken ? target : fallthrough;
      misalign    = taken && (target[ALIGN_BITS-1:0] != '0);
      // A misaligned target is handed to the trap path, so fetch is not redirected.
      redirect    = !misalign &&
                    ((taken != a_pred_taken) || (taken && (a_pred_target != target)));
   end

   // Stage A capture: flush beats self-kill beats new accept beats drain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_valid       <= 1'b0;
         a_op          <= OP_NONE;
         a_pc          <= '0;
         a_imm         <= '0;
         a_rs1         <= '0;
         a_rs2         <= '0;
         a_pred_taken  <= 1'b0;
         a_pred_target <= '0;
      end else if (flush || self_kill) begin
         a_valid <= 1'b0;
      end else if (accept) begin
         a_valid       <= 1'b1;
         a_op          <= in_op;
         a_pc          <= in_pc;
         a_imm         <= in_imm;
         a_rs1         <= in_rs1;
         a_rs2         <= in_rs2;
         a_pred_taken  <= in_pred_taken;
         a_pred_target <= in_pred_target;
      end else if (a_advance) begin
         a_valid <= 1'b0;
      end
   end

   // Stage B output register; outputs hold while stalled by out_ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_taken    <= 1'b0;
         out_next_pc  <= '0;
         out_redirect <= 1'b0;
         out_misalign <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (b_load) begin
         out_valid    <= 1'b1;
         out_taken    <= taken;
         out_next_pc  <= next_pc;
         out_redirect <= redirect;
         out_misalign <= misalign;
      end else if (b_fire) begin
         out_valid <= 1'b0;
      end
   end

`ifdef BRU_STATS_EN
   logic b_branch;

   // Remember whether the entry held in B is a real branch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b_branch <= 1'b0;
      end else if (!flush && b_load) begin
         b_branch <= is_branch;
      end
   end

   // Count results actually handed downstream; both counters wrap naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (b_fire) begin
         if (b_branch) begin
            stat_branches <= stat_branches + 32'd1;
         end
         if (out_redirect) begin
            stat_mispredicts <= stat_mispredicts + 32'd1;
         end
      end
   end
`else
   assign stat_branches    = '0;
   assign stat_mispredicts = '0;
`endif

endmodule
